// File: rtl/rangegate_pkg.sv
// Shared types and constants for the range-gate integrator.
// Holds the FSM state enum and accumulator width helper.
package rangegate_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        ACC
    } state_t;

    localparam int DEF_ADC_BITS   = 14;
    localparam int DEF_GATE_START = 16;
    localparam int DEF_GATE_LEN   = 8;
    localparam int DEF_CNT_BITS   = 8;
    localparam int DEF_ACC_BITS   = 18;

    function automatic int min_acc_bits(
        input int adc_bits,
        input int gate_len
    );
        return adc_bits + $clog2(gate_len);
    endfunction

endpackage

// File: rtl/rangegate_accum_if.sv
// Sample input and sum output bundle for the range-gate integrator.
// slave is the integrator side, master the receiver/consumer side.
interface rangegate_accum_if #(
    parameter int ADCbits = 14,
    parameter int AccBits = 18
);
    logic               trig;
    logic               sampleValid;
    logic [ADCbits-1:0] sample;
    logic [AccBits-1:0] sum;
    logic               sumValid;
    logic               sumReady;
    logic               busy;
    logic               overrun;

    modport master (
        output trig, sampleValid, sample, sumReady,
        input  sum, sumValid, busy, overrun
    );

    modport slave (
        input  trig, sampleValid, sample, sumReady,
        output sum, sumValid, busy, overrun
    );
endinterface

// File: rtl/rangegate_accum_counter.sv
// Loadable up-counter; hit flags the enabled step that reaches term.
// Used for both the depth-offset skip count and the gate count.
module gate_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] din,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         hit
);
    localparam logic [W-1:0] ONE = 1;

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_inc;

    assign cnt_inc = cnt + ONE;
    assign hit     = en && (cnt_inc == term);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= din;
        end else if (en) begin
            cnt <= cnt_inc;
        end
    end
endmodule

// File: rtl/rangegate_accum.sv
// Range-gate integrator: skips GateStart valid samples after trig,
// sums the next GateLen, and offers one sum per pulse repetition.
module rangegate_accum
    import rangegate_pkg::*;
#(
    parameter int ADCbits   = DEF_ADC_BITS,
    parameter int GateStart = DEF_GATE_START,
    parameter int GateLen   = DEF_GATE_LEN,
    parameter int CntBits   = DEF_CNT_BITS,
    parameter int AccBits   = DEF_ACC_BITS
) (
    input logic              clk,
    input logic              rst_n,
    rangegate_accum_if.slave bus
);
    if (AccBits < min_acc_bits(ADCbits, GateLen)) begin : g_chk
        $error("AccBits too small for GateLen samples");
    end

    localparam logic [CntBits-1:0] SKIP_TERM = CntBits'(GateStart);
    localparam logic [CntBits-1:0] GATE_TERM = CntBits'(GateLen);

    state_t state, nstate;

    logic skip_clr, skip_en, skip_hit;
    logic gate_clr, gate_en, gate_hit;
    logic acc_clr, acc_add, done;

    logic [AccBits-1:0] acc, acc_next;
    logic [AccBits-1:0] sum_q;
    logic               sum_valid_q;
    logic               overrun_q;

    gate_counter #(.W(CntBits)) u_skip (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (skip_clr),
        .load (1'b0),
        .din  ('0),
        .en   (skip_en),
        .term (SKIP_TERM),
        .hit  (skip_hit)
    );

    gate_counter #(.W(CntBits)) u_gate (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (gate_clr),
        .load (1'b0),
        .din  ('0),
        .en   (gate_en),
        .term (GATE_TERM),
        .hit  (gate_hit)
    );

    assign acc_next = acc + AccBits'(bus.sample);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nstate;
    end

    // trig restarts from any state and masks a coincident sample
    always_comb begin
        nstate   = state;
        skip_clr = 1'b0;
        skip_en  = 1'b0;
        gate_clr = 1'b0;
        gate_en  = 1'b0;
        acc_clr  = 1'b0;
        acc_add  = 1'b0;
        done     = 1'b0;
        if (bus.trig) begin
            skip_clr = 1'b1;
            gate_clr = 1'b1;
            acc_clr  = 1'b1;
            nstate   = (GateStart == 0) ? ACC : SKIP;
        end else begin
            unique case (state)
                IDLE: ;
                SKIP: begin
                    if (bus.sampleValid) begin
                        skip_en = 1'b1;
                        if (skip_hit) nstate = ACC;
                    end
                end
                ACC: begin
                    if (bus.sampleValid) begin
                        gate_en = 1'b1;
                        acc_add = 1'b1;
                        if (gate_hit) begin
                            done   = 1'b1;
                            nstate = IDLE;
                        end
                    end
                end
                default: nstate = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_clr) begin
            acc <= '0;
        end else if (acc_add) begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            sum_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            overrun_q <= done && sum_valid_q && !bus.sumReady;
            if (done && (!sum_valid_q || bus.sumReady)) begin
                sum_q       <= acc_next;
                sum_valid_q <= 1'b1;
            end else if (sum_valid_q && bus.sumReady) begin
                sum_valid_q <= 1'b0;
            end
        end
    end

    assign bus.sum      = sum_q;
    assign bus.sumValid = sum_valid_q;
    assign bus.overrun  = overrun_q;
    assign bus.busy     = (state != IDLE);
endmodule
